// File: rtl/updown_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// updown_pkg : shared direction/mode encodings and limit clamp helper
// Revision   : 1.0
// ---------------------------------------------------------------------------
package updown_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int MAX_WIDTH = 32;

  // Operates at the widest legal counter width; callers size in and out.
  function automatic logic [MAX_WIDTH-1:0] clamp_to_limit(
    input logic [MAX_WIDTH-1:0] value,
    input logic [MAX_WIDTH-1:0] limit
  );
    return (value > limit) ? limit : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/updown_prescaler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// updown_prescaler : divides enabled ticks by PRESCALE, pulsing on wrap
// Revision         : 1.0
// ---------------------------------------------------------------------------
module updown_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick_in,
  output logic tick_out
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last  = (cnt_q == LAST);
  assign tick_out = tick_in & at_last & ~clr;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_in) begin
      cnt_d = at_last ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/updown_counter_mod.sv
`default_nettype none
// ---------------------------------------------------------------------------
// updown_counter_mod : modulo up/down counter, load, wrap/saturate, tc, ovf
// Optional prescaler : define UPDOWN_PRESCALE_EN          Revision : 1.0
// ---------------------------------------------------------------------------
module updown_counter_mod
  import updown_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat_mode,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] next_val;
  logic             boundary;
  logic             step_req;
  logic             step_tick;

  assign step_req = enable & ~load;

`ifdef UPDOWN_PRESCALE_EN
  updown_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (load),
    .tick_in  (step_req),
    .tick_out (step_tick)
  );
`else
  assign step_tick = step_req;
`endif

  // Candidate value for a step; a count above a lowered limit still hits the up boundary.
  always_comb begin
    boundary = 1'b0;
    next_val = count_q;
    case (up_down)
      DIR_UP: begin
        if (count_q >= limit) begin
          boundary = 1'b1;
          next_val = (sat_mode == MODE_SAT) ? limit : '0;
        end else begin
          next_val = count_q + WIDTH'(1);
        end
      end
      DIR_DOWN: begin
        if (count_q == '0) begin
          boundary = 1'b1;
          next_val = (sat_mode == MODE_WRAP) ? limit : '0;
        end else begin
          next_val = WIDTH'(clamp_to_limit(MAX_WIDTH'(count_q - WIDTH'(1)),
                                           MAX_WIDTH'(limit)));
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;
    if (load) begin
      count_d = WIDTH'(clamp_to_limit(MAX_WIDTH'(load_val), MAX_WIDTH'(limit)));
    end else if (step_tick) begin
      count_d = next_val;
      tc_d    = boundary;
      ovf_d   = ovf_d | boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign at_max  = (count_q == limit);
  assign at_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised up/down counter, successor to the fixed 4-bit up/down counter.
- Adds programmable modulo limit, parallel load, and per-cycle choice of wrap or saturate at the boundaries.
- Adds a terminal-count pulse and a sticky overflow flag.
- Used as a general event, timer and decade counter in the verification task blocks; standalone, no bus interface.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- PRESCALE, 4, enabled cycles per count step; used only with UPDOWN_PRESCALE_EN; legal range 2..256.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; the counter steps only when high.
- up_down  input  1  1 = count up, 0 = count down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- limit  input  WIDTH  upper bound of the count range; count range is 0..limit; sampled every cycle.
- sat_mode  input  1  1 = saturate at the boundaries, 0 = wrap.
- clr_ovf  input  1  clears ovf.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- ovf  output  1  sticky boundary-event flag, registered.
- at_max  output  1  combinational, (count == limit).
- at_zero  output  1  combinational, (count == 0).

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset values: count=0, tc=0, ovf=0.
- Update priority each rising edge: reset > load > step > hold.
- Load:
  - count <= min(load_val, limit).
  - tc <= 0.
  - ovf is unchanged.
  - No step occurs in a load cycle, even if enable is high.
- Step: occurs when enable=1 and load=0 (with the prescaler, only on its strobe).
- Step up:
  - count < limit -> count+1.
  - count >= limit is a boundary event: count <= 0 if sat_mode=0; count <= limit if sat_mode=1.
- Step down:
  - count == 0 is a boundary event: count <= limit if sat_mode=0; count <= 0 if sat_mode=1.
  - otherwise -> count-1, clamped to limit if count > limit.
- limit lowered below count: with no step, count holds its value; the next up-step takes the boundary path.
- tc:
  - 1 for exactly one cycle, in the cycle the post-event count is visible.
  - Asserted for every boundary event, including saturating ones.
  - Consecutive boundary events produce tc=1 continuously.
- ovf:
  - Set by any boundary event.
  - Cleared by clr_ovf.
  - Same-cycle set and clear: set wins.
- limit == 0: count is pinned at 0 and every step is a boundary event.
- Arithmetic: unsigned, modulo 2^WIDTH internally; no carry output.
- Single edge-triggered always block for state; nonblocking assignments only.

Optional Feature:
- Macro: UPDOWN_PRESCALE_EN.
- Defined:
  - A prescale counter (0..PRESCALE-1) advances on each enabled, non-load cycle.
  - The count steps only on the cycle the prescaler wraps, i.e. every PRESCALE enabled cycles.
  - The prescaler clears on reset and on load.
  - enable=0 freezes the prescaler.
  - tc and ovf follow actual count steps only.
- Undefined: the count steps on every enabled cycle; the PRESCALE parameter is ignored; no prescaler logic is synthesised.

Decomposition:
- Package updown_pkg holds:
  - localparam DIR_UP=1'b1, DIR_DOWN=1'b0.
  - localparam MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - function clamp_to_limit(value, limit), used for load and for down-steps above limit.
- One sub-module, updown_prescaler:
  - Parameter PRESCALE.
  - Ports clk, reset, clr, tick_in, tick_out.
  - Instantiated only under UPDOWN_PRESCALE_EN.

Test Plan (WIDTH=4 unless noted):
- Decade up: limit=9, sat_mode=0, up_down=1, enable=1 for 12 cycles from reset -> count 1..9,0,1,2; tc=1 only in the cycle count=0; ovf=1 afterwards.
- Down saturate: load_val=2, limit=9, sat_mode=1, up_down=0, 4 enabled cycles -> count 2,1,0,0,0; tc=1 in the last two cycles; count never wraps to 9.
- Load priority and clamp: load=1, load_val=13, limit=9, enable=1, up_down=1 -> count=9 next cycle with no increment; tc=0.
- Lowered limit: count=8, limit changed to 5, one up-step -> sat_mode=0 gives count=0 with tc=1; sat_mode=1 gives count=5 with tc=1.
- ovf race and reset mid-count: clr_ovf=1 in the same cycle as a boundary event -> ovf stays 1; reset asserted mid-count -> count=0, tc=0, ovf=0 on the next edge.
- UPDOWN_PRESCALE_EN, PRESCALE=4, limit=15: 8 enabled cycles -> count reaches 2; one enable=0 gap -> no extra cycle counted; load mid-period -> prescaler restarts from 0.
